uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Buffered 8N1 UART transmitter for the SoC's serial output path. A byte-wide valid/ready producer interface (CPU-side register glue) feeds a small FIFO, and a shift engine serialises each byte onto ser_tx at a programmable bit period. The divider register is software-visible and shares semantics with the SoC's existing UART divider: bit period = divider value in clk cycles.

Parameters:
FIFO_DEPTH, 8, entries in the TX FIFO; power of two, 2 to 64.
DEFAULT_DIV, 1, divider value loaded at reset.

Ports:
clk  input  1  system clock; all state updates on rising edge.
resetn  input  1  asynchronous active-low reset.
cfg_div_we  input  1  write strobe for the divider register.
cfg_div_di  input  32  new divider value.
cfg_div_do  output  32  current divider register value.
tx_data  input  8  byte to transmit.
tx_valid  input  1  producer offers tx_data.
tx_ready  output  1  FIFO can accept a byte; equals !full.
ser_tx  output  1  serial line, idle high, registered.
busy  output  1  high while a frame is on the line or the FIFO is non-empty.
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0 to FIFO_DEPTH.

Behaviour:
- Reset (async assert, sync release): ser_tx=1, tx_ready=1, busy=0, fifo_level=0, cfg_div_do=DEFAULT_DIV, FIFO empty, engine IDLE. Reset mid-frame aborts the frame; ser_tx returns high immediately and queued bytes are discarded.
- Divider: cfg_div_we at edge E updates the register at E. Effective period = max(cfg_div_do,1). The engine latches the divider when it loads a frame, so a write mid-frame affects only later frames.
- Push: a byte is accepted when tx_valid && tx_ready at a rising edge. tx_ready depends only on the registered occupancy. When the FIFO is full, a push is refused even if a pop happens at the same edge. A simultaneous push and pop at an edge leaves fifo_level unchanged. tx_data is held in the FIFO; there is no bypass path.
- FSM states:
  - IDLE: ser_tx=1. Moves to START at the first edge where the FIFO is non-empty. Pops the head, loads the shift register, latches the divider, and sets ser_tx=0 at that edge.
  - START: holds ser_tx=0 for exactly div cycles.
  - DATA: sends 8 bits, LSB first, each for exactly div cycles.
  - STOP: holds ser_tx=1 for div cycles. At the final STOP cycle edge:
    - if the FIFO is non-empty, pops the next byte and goes straight to START with no idle gap;
    - otherwise goes to IDLE.
- Latency: a byte pushed at edge E into an empty FIFO with the engine IDLE drives ser_tx low from edge E+1. The full frame occupies 10*div cycles.
- Bit counter counts 0..div-1 using a 32-bit compare; it wraps with no off-by-one. div=1 gives one cycle per bit.
- busy = (state != IDLE) || fifo_level != 0. It falls at the edge where STOP completes with the FIFO empty.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap modulo depth. Occupancy is tracked in a separate counter, so full and empty are never ambiguous.

Test Plan:
1. Set div=106, push 0x55 → ser_tx goes low 1 cycle after the push. Each of 10 bits lasts 106 cycles, pattern 0,1,0,1,0,1,0,1,0,1 (start, LSB-first, stop). busy falls after 1060 cycles. A bench receiver sampling at 53-cycle half periods decodes 'U'.
2. Set div=4, push FIFO_DEPTH+1 bytes with tx_valid held high → tx_ready drops when fifo_level=8. The extra byte is accepted only after the first pop. All 9 bytes appear back-to-back with no idle cycles between stop and start bits.
3. Set div=1, push 0x00 then 0xFF → 20 consecutive cycles read 0,00000000,1,0,11111111,1.
4. Write div=10 mid-frame while sending at div=20 → the current frame keeps 20-cycle bits. The next queued frame uses 10-cycle bits. cfg_div_do reads 10 immediately after the write.
5. Deassert resetn during DATA with 3 bytes queued → ser_tx=1, fifo_level=0, busy=0 asynchronously. After release, the line stays idle until a new push.
6. Push and pop at the same edge with fifo_level=3 → fifo_level stays 3, and bytes still transmit in order.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeds a shift engine whose bit
// period is the software-programmable divider value, in clk cycles.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        cfg_div_we,
    input  logic [31:0]                 cfg_div_di,
    output logic [31:0]                 cfg_div_do,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        ser_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [31:0]      cfg_div_r;
    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             push_s;
    logic             pop_s;
    logic             fifo_empty_s;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [31:0]      div_r;
    logic [31:0]      div_nxt_s;
    logic [31:0]      cnt_r;
    logic [31:0]      cnt_nxt_s;
    logic [2:0]       bit_r;
    logic [2:0]       bit_nxt_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_nxt_s;
    logic             ser_r;
    logic             ser_nxt_s;
    logic [31:0]      eff_div_s;
    logic             bit_end_s;

    // A full FIFO refuses pushes even when the engine pops at the same edge.
    assign push_s       = tx_valid && (level_r != FULL_LVL);
    assign fifo_empty_s = (level_r == LVL_W'(0));
    assign eff_div_s    = (cfg_div_r == 32'd0) ? 32'd1 : cfg_div_r;
    assign bit_end_s    = (cnt_r == (div_r - 32'd1));

    assign cfg_div_do = cfg_div_r;
    assign tx_ready   = (level_r != FULL_LVL);
    assign ser_tx     = ser_r;
    assign busy       = (state_r != IDLE) || !fifo_empty_s;
    assign fifo_level = level_r;

    // Divider register, software visible.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cfg_div_r <= 32'(DEFAULT_DIV);
        end else if (cfg_div_we) begin
            cfg_div_r <= cfg_div_di;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= tx_data;
        end
    end

    // FIFO pointers and occupancy counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            level_r  <= LVL_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Shift engine state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
            div_r   <= 32'd1;
            cnt_r   <= 32'd0;
            bit_r   <= 3'd0;
            shift_r <= 8'd0;
            ser_r   <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            div_r   <= div_nxt_s;
            cnt_r   <= cnt_nxt_s;
            bit_r   <= bit_nxt_s;
            shift_r <= shift_nxt_s;
            ser_r   <= ser_nxt_s;
        end
    end

    // Shift engine next state; a frame load pops the head and latches the divider.
    always_comb begin
        state_nxt_s = state_r;
        div_nxt_s   = div_r;
        cnt_nxt_s   = cnt_r;
        bit_nxt_s   = bit_r;
        shift_nxt_s = shift_r;
        ser_nxt_s   = ser_r;
        pop_s       = 1'b0;
        case (state_r)
            IDLE: begin
                ser_nxt_s = 1'b1;
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    shift_nxt_s = mem_r[rd_ptr_r];
                    div_nxt_s   = eff_div_s;
                    cnt_nxt_s   = 32'd0;
                    bit_nxt_s   = 3'd0;
                    ser_nxt_s   = 1'b0;
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    cnt_nxt_s   = 32'd0;
                    ser_nxt_s   = shift_r[0];
                    shift_nxt_s = {1'b0, shift_r[7:1]};
                    state_nxt_s = DATA;
                end else begin
                    cnt_nxt_s = cnt_r + 32'd1;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    cnt_nxt_s = 32'd0;
                    if (bit_r == 3'd7) begin
                        ser_nxt_s   = 1'b1;
                        state_nxt_s = STOP;
                    end else begin
                        bit_nxt_s   = bit_r + 3'd1;
                        ser_nxt_s   = shift_r[0];
                        shift_nxt_s = {1'b0, shift_r[7:1]};
                    end
                end else begin
                    cnt_nxt_s = cnt_r + 32'd1;
                end
            end
            STOP: begin
                if (!bit_end_s) begin
                    cnt_nxt_s = cnt_r + 32'd1;
                end else if (!fifo_empty_s) begin
                    // Back-to-back frame: no idle gap after the stop bit.
                    pop_s       = 1'b1;
                    shift_nxt_s = mem_r[rd_ptr_r];
                    div_nxt_s   = eff_div_s;
                    cnt_nxt_s   = 32'd0;
                    bit_nxt_s   = 3'd0;
                    ser_nxt_s   = 1'b0;
                    state_nxt_s = START;
                end else begin
                    cnt_nxt_s   = 32'd0;
                    ser_nxt_s   = 1'b1;
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                ser_nxt_s   = 1'b1;
                state_nxt_s = IDLE;
            end
        endcase
    end
endmodule
